// File: rtl/pipemdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package pipemdu_pkg;

    localparam int          ITER    = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/pipemdu_if.sv
// EXE-stage side of the multiply/divide unit: launch, MTHI/MTLO writes, status and HI/LO.
interface pipemdu_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             whi;
    logic             wlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, whi, wlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, whi, wlo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/pipemdu_step.sv
// One combinational iteration: shift-add multiply or restoring divide on the
// {hi, lo} accumulator pair (hi = P or 33-bit remainder, lo = M or quotient).
module pipemdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] bmag,
    output logic [WIDTH:0]   hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] trial;
    logic             fits;

    // Multiply: the carry out of the add becomes the new top bit after the right shift.
    assign sum = {1'b0, hi_in[WIDTH-1:0]} + (lo_in[0] ? {1'b0, bmag} : '0);

    // Divide: trial subtraction one bit wider than the shifted remainder exposes its sign.
    assign r_sh  = {hi_in, lo_in[WIDTH-1]};
    assign trial = r_sh - {2'b00, bmag};
    assign fits  = ~trial[WIDTH+1];

    always_comb begin
        if (is_div) begin
            hi_out = fits ? trial[WIDTH:0] : r_sh[WIDTH:0];
            lo_out = {lo_in[WIDTH-2:0], fits};
        end else begin
            hi_out = {1'b0, sum[WIDTH:1]};
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/pipemdu.sv
// Multiply/divide sequencer: IDLE -> 32 CALC iterations -> FIX, with the HI/LO
// architectural registers and the busy interlock for the pipeline.
module pipemdu
    import pipemdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    pipemdu_if.slave  md
);

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    md_op_e           op_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_in = md_op_e'(md.op);
    assign a_neg = op_is_signed(op_in) & md.a[WIDTH-1];
    assign b_neg = op_is_signed(op_in) & md.b[WIDTH-1];
    assign a_mag = a_neg ? -md.a : md.a;
    assign b_mag = b_neg ? -md.b : md.b;

    pipemdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_is_div(op_q)),
        .hi_in  (acc_hi_q),
        .lo_in  (acc_lo_q),
        .bmag   (bmag_q),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    // On divide-by-zero the remainder path already yields the original dividend.
    assign rem_fix  = rem_neg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        bmag_d    = bmag_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (md.start) begin
                    state_d   = S_CALC;
                    cnt_d     = 5'(ITER - 1);
                    op_d      = op_in;
                    bmag_d    = b_mag;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    div0_d    = (md.b == '0);
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                    busy_d    = 1'b1;
                end else begin
                    if (md.whi) hi_d = md.wdata;
                    if (md.wlo) lo_d = md.wdata;
                end
            end
            S_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_FIX: begin
                if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = div0_q ? WIDTH'(DIV0_LO) : quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULTU;
            bmag_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            bmag_q    <= bmag_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_pipemdu.sv
// Scoreboard bench for pipemdu: the stimulus pushes reference results, a
// negedge monitor pops them on done and also checks HI/LO hold while busy.
module tb_pipemdu;
    import pipemdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          start_cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_run = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pipemdu_if #(.WIDTH(32)) md_if ();

    pipemdu #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .md    (md_if)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS MD semantics with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, m;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00:   r = ua * ub;
            2'b01:   r = sa * sb;
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    r = {32'(ua % ub), 32'(ua / ub)};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {32'(m), 32'(q)};
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: result, latency and busy length on done; HI/LO hold while busy.
    always @(negedge clock) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (md_if.busy) begin
                busy_run++;
                check("hold_hi", md_if.hi, model_hi);
                check("hold_lo", md_if.lo, model_lo);
            end
            if (md_if.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", md_if.done, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_hi", md_if.hi, mon_e.hi);
                    check("result_lo", md_if.lo, mon_e.lo);
                    check("done_latency", cyc - mon_e.start_cyc, 33);
                    check("busy_len", busy_run, 33);
                    model_hi = mon_e.hi;
                    model_lo = mon_e.lo;
                end
                busy_run = 0;
            end
        end
    end

    // Issues one operation once the unit is idle; returns just after the accepting edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_wlo, output int start_cyc);
        exp_t        e;
        logic [63:0] r;
        int          guard = 0;
        while (md_if.busy && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("idle_wait", md_if.busy, 1'b0);
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.a     = a;
        md_if.b     = b;
        if (with_wlo) begin
            md_if.wlo   = 1'b1;
            md_if.wdata = 32'h5A5A_0F0F;
        end
        r = ref_md(op, a, b);
        @(posedge clock); #1;
        md_if.start = 1'b0;
        md_if.wlo   = 1'b0;
        e.hi        = r[63:32];
        e.lo        = r[31:0];
        e.start_cyc = cyc;
        start_cyc   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || md_if.busy) && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc1, sc2, sc;
        reset       = 1'b1;
        md_if.start = 1'b0;
        md_if.op    = 2'b00;
        md_if.a     = '0;
        md_if.b     = '0;
        md_if.whi   = 1'b0;
        md_if.wlo   = 1'b0;
        md_if.wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi", md_if.hi, 32'd0);
        check("rst_lo", md_if.lo, 32'd0);
        check("rst_busy", md_if.busy, 1'b0);
        check("rst_done", md_if.done, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, sc);
        drain();
        check("multu_max_hi", md_if.hi, 32'hFFFF_FFFE);
        check("multu_max_lo", md_if.lo, 32'h0000_0001);

        do_op(OP_MULT, -32'd3, 32'd7, 1'b0, sc);
        drain();
        check("mult_neg_hi", md_if.hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", md_if.lo, 32'hFFFF_FFEB);

        do_op(OP_DIV, -32'd7, 32'd2, 1'b0, sc);
        drain();
        check("div_neg_lo", md_if.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", md_if.hi, 32'hFFFF_FFFF);

        do_op(OP_DIVU, 32'h1234_5678, 32'd0, 1'b0, sc);
        drain();
        check("divu0_lo", md_if.lo, 32'hFFFF_FFFF);
        check("divu0_hi", md_if.hi, 32'h1234_5678);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, sc);
        drain();
        check("div_ovf_lo", md_if.lo, 32'h8000_0000);
        check("div_ovf_hi", md_if.hi, 32'h0000_0000);

        // MTHI / MTLO in IDLE land at the next edge.
        md_if.whi   = 1'b1;
        md_if.wdata = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        md_if.whi = 1'b0;
        model_hi  = 32'hA5A5_A5A5;
        check("mthi_idle", md_if.hi, 32'hA5A5_A5A5);
        md_if.wlo   = 1'b1;
        md_if.wdata = 32'h0BAD_F00D;
        @(posedge clock); #1;
        md_if.wlo = 1'b0;
        model_lo  = 32'h0BAD_F00D;
        check("mtlo_idle", md_if.lo, 32'h0BAD_F00D);

        // MTHI during cycle 10 of an operation is dropped.
        do_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, sc);
        repeat (9) @(posedge clock);
        #1;
        md_if.whi   = 1'b1;
        md_if.wdata = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        md_if.whi = 1'b0;
        drain();
        check("mthi_busy_hi", md_if.hi, 32'd6);
        check("mthi_busy_lo", md_if.lo, 32'd142);

        // start together with wlo: the start wins.
        do_op(OP_MULTU, 32'd6, 32'd7, 1'b1, sc);
        drain();
        check("start_wlo_lo", md_if.lo, 32'd42);

        // Reset in cycle 15 of a DIVU.
        do_op(OP_DIVU, 32'hDEAD_BEEF, 32'd13, 1'b0, sc);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_hi", md_if.hi, 32'd0);
        check("midrst_lo", md_if.lo, 32'd0);
        check("midrst_busy", md_if.busy, 1'b0);
        check("midrst_done", md_if.done, 1'b0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        do_op(OP_MULTU, 32'd6, 32'd7, 1'b0, sc);
        drain();
        check("after_rst_lo", md_if.lo, 32'd42);
        check("after_rst_hi", md_if.hi, 32'd0);

        // Back-to-back: the second start must be accepted 34 edges after the first.
        do_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, sc1);
        do_op(OP_DIV, 32'hFFFF_FF00, 32'd10, 1'b0, sc2);
        check("b2b_gap", sc2 - sc1, 34);
        drain();

        for (int i = 0; i < 24; i++) begin
            do_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), sc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
